mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_seq_pkg.sv | 15 +
 rtl/mac_sequencer.sv | 113 +++++++++++
 tb/tb_mac_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC sequencer: FSM state encoding and
// the fixed pipeline drain length between the last operand pop and capture.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/mac_sequencer.sv
// Feeds VEC_LEN operand pairs from two valid/ready streams into an external
// accumulator, then captures the dot product once the accumulator has settled.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    b_ready,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_ain,
  output logic [DATA_WIDTH-1:0]   mac_bin,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic [3*DATA_WIDTH-1:0] result,
  output logic                    result_valid,
  output logic                    busy
);

  localparam int CW  = $clog2(VEC_LEN + 1);
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CW-1:0]  LEN_C      = CW'(VEC_LEN);
  localparam logic [CW-1:0]  LEN_LAST   = CW'(VEC_LEN - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  state_t         state;
  logic [CW-1:0]  count;
  logic [DCW-1:0] drain_cnt;
  logic           room;
  logic           fire;

  // Both streams pop together: each ready only depends on the other side's valid.
  assign room    = (state == RUN) && (count < LEN_C);
  assign fire    = room && a_valid && b_valid;
  assign a_ready = room && b_valid;
  assign b_ready = room && a_valid;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      drain_cnt    <= '0;
      mac_en       <= 1'b0;
      mac_clr      <= 1'b0;
      mac_ain      <= '0;
      mac_bin      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      mac_en       <= 1'b0;
      mac_clr      <= 1'b0;
      result_valid <= 1'b0;
      // Abort clears the accumulator so a cancelled partial sum never leaks out.
      if (state != IDLE && abort) begin
        state   <= IDLE;
        mac_clr <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= CLEAR;
              mac_clr <= 1'b1;
              count   <= '0;
            end
          end
          CLEAR: begin
            state <= RUN;
          end
          RUN: begin
            if (fire) begin
              mac_ain <= a_data;
              mac_bin <= b_data;
              mac_en  <= 1'b1;
              count   <= count + 1'b1;
              if (count == LEN_LAST) begin
                state     <= DRAIN;
                drain_cnt <= '0;
              end
            end
          end
          DRAIN: begin
            // Wait for the final product to land in the accumulator before capture.
            if (drain_cnt == DRAIN_LAST) begin
              result       <= mac_cout;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomised and directed bench for mac_sequencer with a behavioural accumulator
// and a rule-level expectation model built from the applied stimulus.
module tb_mac_sequencer;

  localparam int VL = 8;
  localparam int NC = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, a_valid, b_valid;
  logic [7:0]  a_data, b_data;
  logic        a_ready, b_ready, mac_en, mac_clr, result_valid, busy;
  logic [7:0]  mac_ain, mac_bin;
  logic [23:0] mac_cout, result;

  logic        big_start;
  logic        big_a_ready, big_b_ready, big_en, big_clr, big_rv, big_busy;
  logic [7:0]  big_ain, big_bin;
  logic [23:0] big_cout, big_result;

  always #5 clk = ~clk;

  mac_sequencer #(.DATA_WIDTH(8), .VEC_LEN(VL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_ain(mac_ain), .mac_bin(mac_bin),
    .mac_cout(mac_cout), .result(result), .result_valid(result_valid), .busy(busy)
  );

  mac_sequencer #(.DATA_WIDTH(8), .VEC_LEN(256)) dut_big (
    .clk(clk), .rst_n(rst_n), .start(big_start), .abort(1'b0),
    .a_valid(1'b1), .a_data(8'hFF), .a_ready(big_a_ready),
    .b_valid(1'b1), .b_data(8'hFF), .b_ready(big_b_ready),
    .mac_en(big_en), .mac_clr(big_clr), .mac_ain(big_ain), .mac_bin(big_bin),
    .mac_cout(big_cout), .result(big_result), .result_valid(big_rv), .busy(big_busy)
  );

  // Behavioural accumulators standing in for the parent's MAC units.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_cout <= '0;
    else if (mac_clr) mac_cout <= '0;
    else if (mac_en) mac_cout <= mac_cout + 24'(mac_ain) * 24'(mac_bin);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) big_cout <= '0;
    else if (big_clr) big_cout <= '0;
    else if (big_en) big_cout <= big_cout + 24'(big_ain) * 24'(big_bin);
  end

  typedef struct packed {
    logic        ra, rb, en, clr, rv, busy;
    logic [7:0]  ain, bin;
    logic [23:0] res;
  } snap_t;

  snap_t       obs[NC], exp_s[NC];
  bit          av[NC], bv[NC], st[NC], ab[NC];
  logic [7:0]  ad[NC], bd[NC];
  int          n_cyc, g_rvc;
  logic [23:0] g_res = '0;
  logic [7:0]  g_a = '0, g_b = '0;
  int          errors = 0, checks = 0;

  function automatic snap_t sample();
    snap_t s;
    s.ra = a_ready; s.rb = b_ready; s.en = mac_en; s.clr = mac_clr;
    s.rv = result_valid; s.busy = busy; s.ain = mac_ain; s.bin = mac_bin;
    s.res = result;
    return s;
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < NC; k++) begin
      av[k] = 0; bv[k] = 0; st[k] = 0; ab[k] = 0; ad[k] = '0; bd[k] = '0;
    end
  endtask

  // a = 1..8 in pop order, b = 2; b_valid drops for slen cycles from cycle s0.
  task automatic load_basic(input int s0, input int slen);
    int idx;
    clear_stim();
    st[0] = 1;
    idx = 0;
    for (int k = 2; k < NC; k++) begin
      av[k] = 1;
      bv[k] = !(k >= s0 && k < s0 + slen);
      ad[k] = 8'(idx + 1);
      bd[k] = 8'd2;
      if (bv[k] && idx < VL) idx++;
    end
  endtask

  // Expected per-cycle outputs: pops are the first VL cycles from cycle 2 with both
  // valids high, the result lands 3 cycles after the last pop, abort ends it early.
  task automatic build_model();
    int pops, last, ka, rvc, endc, run_end;
    bit fk[NC];
    bit fire_prev, done_ok;
    logic [23:0] sum, cr;
    logic [7:0] ca, cb;
    pops = 0; last = -1; sum = '0;
    for (int k = 0; k < NC; k++) fk[k] = 0;
    for (int k = 2; k < NC; k++) begin
      if (pops < VL && av[k] && bv[k]) begin
        fk[k] = 1; pops++; last = k;
        sum = sum + 24'(ad[k]) * 24'(bd[k]);
      end
    end
    rvc = last + 3;
    ka = -1;
    for (int k = NC - 1; k >= 1; k--) if (ab[k] && k <= rvc) ka = k;
    endc    = (ka >= 0) ? ka : rvc;
    run_end = (ka >= 0 && ka <= last) ? ka : last;
    done_ok = (ka < 0) || (ka == rvc);
    n_cyc   = (endc + 4 < NC) ? endc + 4 : NC;
    ca = g_a; cb = g_b; cr = g_res;
    for (int k = 0; k < n_cyc; k++) begin
      fire_prev = (k >= 1) && fk[k-1] && (ka < 0 || k - 1 < ka);
      if (fire_prev) begin ca = ad[k-1]; cb = bd[k-1]; end
      if (k == rvc && done_ok) cr = sum;
      exp_s[k].ra   = (k >= 2 && k <= run_end) && bv[k];
      exp_s[k].rb   = (k >= 2 && k <= run_end) && av[k];
      exp_s[k].en   = fire_prev;
      exp_s[k].clr  = (k == 1) || (ka >= 0 && k == ka + 1);
      exp_s[k].rv   = (k == rvc) && done_ok;
      exp_s[k].busy = (k >= 1) && (k <= endc);
      exp_s[k].ain  = ca;
      exp_s[k].bin  = cb;
      exp_s[k].res  = cr;
    end
    g_a = ca; g_b = cb; g_res = cr; g_rvc = rvc;
  endtask

  task automatic drive_op();
    for (int k = 0; k < n_cyc; k++) begin
      start = st[k]; abort = ab[k]; a_valid = av[k]; b_valid = bv[k];
      a_data = ad[k]; b_data = bd[k];
      #1;
      obs[k] = sample();
      @(posedge clk); #1;
    end
    start = 0; abort = 0; a_valid = 0; b_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; abort = 0; a_valid = 1; b_valid = 1;
    a_data = 8'h5A; b_data = 8'hA5; big_start = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sample() !== '0) begin
      errors++; $display("[TB] FAIL reset_state got=%h exp=%h", sample(), snap_t'('0));
    end
    checks++;
    if ({big_busy, big_rv, big_en, big_clr, big_result} !== '0) begin
      errors++; $display("[TB] FAIL reset_big got=%b/%h exp=0/0", big_busy, big_result);
    end
    rst_n = 1;
    #1;
    checks++;
    if (sample() !== '0) begin
      errors++; $display("[TB] FAIL idle_after_release got=%h exp=%h", sample(), snap_t'('0));
    end
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
  endtask

  task automatic test_basic();
    load_basic(0, 0); build_model(); drive_op();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (obs[k] !== exp_s[k]) begin
        errors++; $display("[TB] FAIL basic cyc=%0d got=%h exp=%h", k, obs[k], exp_s[k]);
      end
    end
    checks++;
    if (obs[12].rv !== 1'b1 || obs[12].res !== 24'd72) begin
      errors++; $display("[TB] FAIL basic_result rv=%b res=%0d exp rv=1 res=72", obs[12].rv, obs[12].res);
    end
  endtask

  task automatic test_stall();
    load_basic(4, 5); build_model(); drive_op();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (obs[k] !== exp_s[k]) begin
        errors++; $display("[TB] FAIL stall cyc=%0d got=%h exp=%h", k, obs[k], exp_s[k]);
      end
    end
    checks++;
    if (obs[17].rv !== 1'b1 || obs[17].res !== 24'd72) begin
      errors++; $display("[TB] FAIL stall_result rv=%b res=%0d exp rv=1 res=72", obs[17].rv, obs[17].res);
    end
  endtask

  task automatic test_abort();
    clear_stim();
    st[0] = 1;
    for (int k = 2; k <= 4; k++) begin
      av[k] = 1; bv[k] = 1; ad[k] = 8'(k + 10); bd[k] = 8'd3;
    end
    ab[5] = 1;
    build_model(); drive_op();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (obs[k] !== exp_s[k]) begin
        errors++; $display("[TB] FAIL abort cyc=%0d got=%h exp=%h", k, obs[k], exp_s[k]);
      end
    end
    checks++;
    if (obs[6].clr !== 1'b1 || obs[6].busy !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_exit clr=%b busy=%b exp clr=1 busy=0", obs[6].clr, obs[6].busy);
    end
    load_basic(0, 0); build_model(); drive_op();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (obs[k] !== exp_s[k]) begin
        errors++; $display("[TB] FAIL abort_rerun cyc=%0d got=%h exp=%h", k, obs[k], exp_s[k]);
      end
    end
  endtask

  // start+abort together in IDLE, then abort during DONE.
  task automatic test_abort_edges();
    load_basic(0, 0);
    ab[0] = 1; ab[12] = 1;
    build_model(); drive_op();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (obs[k] !== exp_s[k]) begin
        errors++; $display("[TB] FAIL abort_edges cyc=%0d got=%h exp=%h", k, obs[k], exp_s[k]);
      end
    end
    checks++;
    if (obs[12].rv !== 1'b1 || obs[12].res !== 24'd72) begin
      errors++; $display("[TB] FAIL abort_done rv=%b res=%0d exp rv=1 res=72", obs[12].rv, obs[12].res);
    end
  endtask

  // Random valids and data, with start re-pulsed throughout the operation.
  task automatic test_random();
    int rv_seen;
    for (int it = 0; it < 4; it++) begin
      clear_stim();
      st[0] = 1;
      for (int k = 2; k < NC; k++) begin
        av[k] = (k >= 40) || ($urandom_range(0, 3) != 0);
        bv[k] = (k >= 40) || ($urandom_range(0, 3) != 0);
        ad[k] = 8'($urandom);
        bd[k] = 8'($urandom);
      end
      build_model();
      for (int k = 1; k <= g_rvc; k++) st[k] = ($urandom_range(0, 2) == 0);
      drive_op();
      rv_seen = 0;
      for (int k = 0; k < n_cyc; k++) begin
        checks++;
        if (obs[k] !== exp_s[k]) begin
          errors++; $display("[TB] FAIL random%0d cyc=%0d got=%h exp=%h", it, k, obs[k], exp_s[k]);
        end
        if (obs[k].rv === 1'b1) rv_seen++;
      end
      checks++;
      if (rv_seen != 1) begin
        errors++; $display("[TB] FAIL random%0d_rv_count got=%0d exp=1", it, rv_seen);
      end
    end
  endtask

  task automatic test_reset_mid();
    load_basic(0, 0);
    for (int k = 0; k < 6; k++) begin
      start = st[k]; a_valid = av[k]; b_valid = bv[k]; a_data = ad[k]; b_data = bd[k];
      @(posedge clk); #1;
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (sample() !== '0) begin
      errors++; $display("[TB] FAIL reset_mid got=%h exp=%h", sample(), snap_t'('0));
    end
    @(posedge clk); #1;
    rst_n = 1;
    start = 0; a_valid = 0; b_valid = 0;
    g_res = '0; g_a = '0; g_b = '0;
    @(posedge clk); #1;
    load_basic(0, 0); build_model(); drive_op();
    for (int k = 0; k < n_cyc; k++) begin
      checks++;
      if (obs[k] !== exp_s[k]) begin
        errors++; $display("[TB] FAIL reset_rerun cyc=%0d got=%h exp=%h", k, obs[k], exp_s[k]);
      end
    end
  endtask

  task automatic test_full_scale();
    int rv_cnt, rv_k;
    logic [23:0] rv_res;
    rv_cnt = 0; rv_k = -1; rv_res = '0;
    for (int k = 0; k < 300; k++) begin
      big_start = (k == 0);
      #1;
      if (big_rv === 1'b1) begin rv_cnt++; rv_k = k; rv_res = big_result; end
      @(posedge clk); #1;
    end
    big_start = 0;
    checks++;
    if (rv_cnt != 1 || rv_k != 260) begin
      errors++; $display("[TB] FAIL full_timing got cnt=%0d cyc=%0d exp cnt=1 cyc=260", rv_cnt, rv_k);
    end
    checks++;
    if (rv_res !== 24'hFE0100) begin
      errors++; $display("[TB] FAIL full_result got=%h exp=fe0100", rv_res);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_abort_edges();
    test_random();
    test_reset_mid();
    test_full_scale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
